// File: rtl/conv_result_streamer.sv
// Captures a programmed number of convolution result bytes into a buffer, then
// replays them in capture order over a valid/ready byte stream.
module conv_result_streamer #(
   parameter int N         = 8,
   parameter int Depth     = 1024,
   parameter int CountBits = $clog2(Depth) + 1
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic                 start_i,
   input  logic [CountBits-1:0] result_count_i,
   input  logic [N-1:0]         conv_i,
   input  logic                 conv_valid_i,
   output logic [N-1:0]         tx_data_o,
   output logic                 tx_valid_o,
   input  logic                 tx_ready_i,
   output logic                 tx_last_o,
   output logic                 busy_o,
   output logic                 done_o,
   output logic                 err_o
);

   localparam int AddrBits = $clog2(Depth);

   localparam logic [1:0] S_IDLE     = 2'd0;
   localparam logic [1:0] S_CAPTURE  = 2'd1;
   localparam logic [1:0] S_TRANSMIT = 2'd2;
   localparam logic [1:0] S_DONE     = 2'd3;

   logic [1:0]           r_state;
   logic [CountBits-1:0] r_count;
   logic [CountBits-1:0] r_wr_ptr;
   logic [CountBits-1:0] r_rd_ptr;
   logic                 r_err;
   logic                 r_rd_vld;
   logic                 r_rd_last;
   logic [N-1:0]         r_mem_q;
   logic [N-1:0]         r_mem [Depth];
   logic [N-1:0]         r_fifo_data [2];
   logic [1:0]           r_fifo_last;
   logic [1:0]           r_fifo_cnt;

   logic                 w_start_ok;
   logic                 w_over;
   logic                 w_wr;
   logic                 w_pop;
   logic                 w_push;
   logic [1:0]           w_occ;
   logic                 w_issue;

   assign w_start_ok = (r_state == S_IDLE) && start_i;
   assign w_over     = result_count_i > CountBits'(Depth);
   assign w_wr       = (r_state == S_CAPTURE) && conv_valid_i;
   assign w_pop      = tx_valid_o && tx_ready_i;
   assign w_push     = r_rd_vld;
   // A read is issued only if its byte is guaranteed a skid slot when it lands.
   assign w_occ      = r_fifo_cnt + {1'b0, r_rd_vld};
   assign w_issue    = (r_state == S_TRANSMIT) && (r_rd_ptr < r_count) &&
                       ((w_occ <= 2'd1) || ((w_occ == 2'd2) && w_pop));

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_state   <= S_IDLE;
         r_count   <= '0;
         r_wr_ptr  <= '0;
         r_rd_ptr  <= '0;
         r_err     <= 1'b0;
         r_rd_vld  <= 1'b0;
         r_rd_last <= 1'b0;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so every register
         // samples pre-edge values regardless of statement order.
         r_rd_vld  <= w_issue;
         r_rd_last <= (r_rd_ptr == r_count - CountBits'(1));
         if (w_start_ok) r_err <= w_over;
         else if (conv_valid_i && (r_state != S_CAPTURE)) r_err <= 1'b1;
         case (r_state)
            S_IDLE: begin
               if (start_i) begin
                  r_wr_ptr <= '0;
                  r_count  <= w_over ? CountBits'(Depth) : result_count_i;
                  r_state  <= (result_count_i == '0) ? S_DONE : S_CAPTURE;
               end
            end
            S_CAPTURE: begin
               if (conv_valid_i) begin
                  r_wr_ptr <= r_wr_ptr + CountBits'(1);
                  if (r_wr_ptr == r_count - CountBits'(1)) begin
                     r_rd_ptr <= '0;
                     r_state  <= S_TRANSMIT;
                  end
               end
            end
            S_TRANSMIT: begin
               if (w_issue) r_rd_ptr <= r_rd_ptr + CountBits'(1);
               if (w_pop && r_fifo_last[0]) r_state <= S_DONE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   // NOTE: the buffer has no reset; its contents are always written before read.
   always_ff @(posedge clk_i) begin
      if (w_wr) r_mem[r_wr_ptr[AddrBits-1:0]] <= conv_i;
      if (w_issue) r_mem_q <= r_mem[r_rd_ptr[AddrBits-1:0]];
   end

   // Two-entry skid buffer; entry 0 is the head presented on tx_*.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_fifo_data[0] <= '0;
         r_fifo_data[1] <= '0;
         r_fifo_last    <= '0;
         r_fifo_cnt     <= '0;
      end else if (w_push && !w_pop) begin
         if (r_fifo_cnt == 2'd0) begin
            r_fifo_data[0] <= r_mem_q;
            r_fifo_last[0] <= r_rd_last;
         end else begin
            r_fifo_data[1] <= r_mem_q;
            r_fifo_last[1] <= r_rd_last;
         end
         r_fifo_cnt <= r_fifo_cnt + 2'd1;
      end else if (!w_push && w_pop) begin
         r_fifo_data[0] <= r_fifo_data[1];
         r_fifo_last[0] <= r_fifo_last[1];
         r_fifo_cnt     <= r_fifo_cnt - 2'd1;
      end else if (w_push && w_pop) begin
         if (r_fifo_cnt == 2'd1) begin
            r_fifo_data[0] <= r_mem_q;
            r_fifo_last[0] <= r_rd_last;
         end else begin
            r_fifo_data[0] <= r_fifo_data[1];
            r_fifo_last[0] <= r_fifo_last[1];
            r_fifo_data[1] <= r_mem_q;
            r_fifo_last[1] <= r_rd_last;
         end
      end
   end

   assign tx_data_o  = r_fifo_data[0];
   assign tx_valid_o = (r_fifo_cnt != 2'd0);
   assign tx_last_o  = tx_valid_o && r_fifo_last[0];
   assign busy_o     = (r_state == S_CAPTURE) || (r_state == S_TRANSMIT);
   assign done_o     = (r_state == S_DONE);
   assign err_o      = r_err;

endmodule

// File: tb/tb_conv_result_streamer.sv
// Directed bench for conv_result_streamer: captured bytes are queued as expected
// beats and matched against the tx stream by a negedge monitor.
module tb_conv_result_streamer;

   localparam int N         = 8;
   localparam int Depth     = 1024;
   localparam int CountBits = $clog2(Depth) + 1;

   logic                 clk_i = 1'b0;
   logic                 rst_ni = 1'b0;
   logic                 start_i = 1'b0;
   logic [CountBits-1:0] result_count_i = '0;
   logic [N-1:0]         conv_i = '0;
   logic                 conv_valid_i = 1'b0;
   logic [N-1:0]         tx_data_o;
   logic                 tx_valid_o;
   logic                 tx_ready_i = 1'b1;
   logic                 tx_last_o;
   logic                 busy_o;
   logic                 done_o;
   logic                 err_o;

   conv_result_streamer #(.N(N), .Depth(Depth), .CountBits(CountBits)) dut (
      .clk_i          (clk_i),
      .rst_ni         (rst_ni),
      .start_i        (start_i),
      .result_count_i (result_count_i),
      .conv_i         (conv_i),
      .conv_valid_i   (conv_valid_i),
      .tx_data_o      (tx_data_o),
      .tx_valid_o     (tx_valid_o),
      .tx_ready_i     (tx_ready_i),
      .tx_last_o      (tx_last_o),
      .busy_o         (busy_o),
      .done_o         (done_o),
      .err_o          (err_o)
   );

   always #5 clk_i = ~clk_i;

   int errors = 0;
   int checks = 0;
   logic [8:0] exp_q [$];   // {last, data}
   int beats, done_cnt, cyc, first_cyc, last_cyc;
   bit busy_seen;
   bit rdy_rand = 1'b0;
   bit prev_stall;
   logic [N-1:0] prev_data;
   logic prev_last;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   initial begin
      forever begin
         @(posedge clk_i);
         #1;
         tx_ready_i = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
      end
   end

   // Monitor: beats are sampled at negedge, so valid&&ready here transfers on the next posedge.
   always @(negedge clk_i) begin
      logic [8:0] e;
      cyc++;
      if (!rst_ni) begin
         prev_stall = 1'b0;
      end else begin
         if (busy_o) busy_seen = 1'b1;
         if (done_o) done_cnt++;
         if (prev_stall) begin
            check("stall_valid", 32'(tx_valid_o), 32'd1);
            check("stall_data", 32'(tx_data_o), 32'(prev_data));
            check("stall_last", 32'(tx_last_o), 32'(prev_last));
         end
         if (tx_valid_o && tx_ready_i) begin
            if (exp_q.size() == 0) begin
               check("unexpected_beat", 32'(tx_data_o), 32'hFFFF_FFFF);
            end else begin
               e = exp_q.pop_front();
               check("beat_data", 32'(tx_data_o), 32'(e[7:0]));
               check("beat_last", 32'(tx_last_o), 32'(e[8]));
            end
            if (beats == 0) first_cyc = cyc;
            last_cyc = cyc;
            beats++;
         end
         prev_stall = tx_valid_o && !tx_ready_i;
         prev_data  = tx_data_o;
         prev_last  = tx_last_o;
      end
   end

   task automatic clear_stats();
      beats = 0;
      done_cnt = 0;
      busy_seen = 1'b0;
   endtask

   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   task automatic start(input int cnt);
      start_i = 1'b1;
      result_count_i = CountBits'(cnt);
      step();
      start_i = 1'b0;
   endtask

   // Drives n bytes with data base+i; the first 'keep' are expected on tx.
   task automatic send(input int n, input int keep, input logic [7:0] base, input int gap);
      for (int i = 0; i < n; i++) begin
         conv_valid_i = 1'b1;
         conv_i = base + 8'(i);
         if (i < keep) exp_q.push_back({(i == keep - 1), base + 8'(i)});
         step();
         conv_valid_i = 1'b0;
         repeat (gap) step();
      end
   endtask

   task automatic wait_done(input string tag, input int budget);
      bit got = 1'b0;
      for (int i = 0; i < budget && !got; i++) begin
         @(negedge clk_i);
         if (done_o) begin
            got = 1'b1;
            check({tag, "_busy_at_done"}, 32'(busy_o), 32'd0);
         end
      end
      check({tag, "_done_seen"}, 32'(got), 32'd1);
      step();
      check({tag, "_done_low_after"}, 32'(done_o), 32'd0);
      check({tag, "_valid_low_after"}, 32'(tx_valid_o), 32'd0);
      step();
      check({tag, "_done_once"}, 32'(done_cnt), 32'd1);
      check({tag, "_queue_empty"}, 32'(exp_q.size()), 32'd0);
   endtask

   initial begin
      clear_stats();
      repeat (3) step();
      check("rst_valid", 32'(tx_valid_o), 32'd0);
      check("rst_data", 32'(tx_data_o), 32'd0);
      check("rst_flags", {28'd0, tx_last_o, busy_o, done_o, err_o}, 32'd0);
      rst_ni = 1'b1;
      step();

      // Basic: four back-to-back bytes, ready high.
      clear_stats();
      start(4);
      check("basic_busy", 32'(busy_o), 32'd1);
      send(4, 4, 8'h11, 0);
      wait_done("basic", 50);
      check("basic_beats", 32'(beats), 32'd4);
      check("basic_err", 32'(err_o), 32'd0);

      // Backpressure with gapped capture, then overrun during transmit.
      clear_stats();
      rdy_rand = 1'b1;
      start(8);
      send(8, 8, 8'h01, 1);
      check("bp_err_before", 32'(err_o), 32'd0);
      send(3, 0, 8'hE0, 0);
      check("overrun_err", 32'(err_o), 32'd1);
      wait_done("bp", 300);
      check("bp_beats", 32'(beats), 32'd8);
      check("overrun_sticky", 32'(err_o), 32'd1);
      rdy_rand = 1'b0;

      // Zero count: done without beats; start clears the overrun flag.
      clear_stats();
      start(0);
      check("zero_err_cleared", 32'(err_o), 32'd0);
      wait_done("zero", 2);
      check("zero_beats", 32'(beats), 32'd0);
      check("zero_busy", 32'(busy_seen), 32'd0);

      // Clamp: request Depth+1 results, only Depth are streamed.
      clear_stats();
      start(Depth + 1);
      check("clamp_err", 32'(err_o), 32'd1);
      send(Depth + 1, Depth, 8'h00, 0);
      wait_done("clamp", 3000);
      check("clamp_beats", 32'(beats), 32'(Depth));

      // Full depth: no bubbles with ready held high.
      clear_stats();
      start(Depth);
      check("full_err_cleared", 32'(err_o), 32'd0);
      send(Depth, Depth, 8'h00, 0);
      wait_done("full", 3000);
      check("full_beats", 32'(beats), 32'(Depth));
      check("full_span", 32'(last_cyc - first_cyc), 32'(Depth - 1));

      // Reset mid-transmit, then a fresh short stream.
      clear_stats();
      start(5);
      send(5, 5, 8'h51, 0);
      for (int i = 0; i < 50 && beats < 2; i++) begin
         @(negedge clk_i);
         #1;
      end
      check("mid_two_beats", 32'(beats), 32'd2);
      @(posedge clk_i);
      #2;
      rst_ni = 1'b0;
      #1;
      check("mid_rst_valid", 32'(tx_valid_o), 32'd0);
      check("mid_rst_data", 32'(tx_data_o), 32'd0);
      check("mid_rst_flags", {28'd0, tx_last_o, busy_o, done_o, err_o}, 32'd0);
      exp_q.delete();
      repeat (2) step();
      rst_ni = 1'b1;
      step();
      clear_stats();
      start(2);
      send(2, 2, 8'hA1, 0);
      wait_done("post_rst", 50);
      check("post_rst_beats", 32'(beats), 32'd2);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
